// File: rtl/trace_time_stamper.sv
// Captures {timestamp, value} change records into a small FWFT FIFO and
// sequences end-of-test: run for a fixed cycle count, drain, then finish.
module trace_time_stamper #(
    parameter int PERIOD_UNITS = 1,
    parameter int VAL_W        = 32,
    parameter int TS_W         = 48,
    parameter int DEPTH        = 4,
    parameter int FINISH_CYC   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [VAL_W-1:0] value_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TS_W-1:0]  out_ts,
    output logic [VAL_W-1:0] out_value,
    output logic [7:0]       drop_cnt,
    output logic             ts_wrap,
    output logic             finish_o,
    output logic             done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FINISH_CYC) + 1;
    localparam logic [CW-1:0]   LAST_CYC = CW'(FINISH_CYC - 1);
    localparam logic [TS_W:0]   STEP     = (TS_W+1)'(PERIOD_UNITS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cyc;
    logic [TS_W-1:0]   r_ts;
    logic [VAL_W-1:0]  r_last;
    logic [TS_W-1:0]   r_mem_ts  [DEPTH];
    logic [VAL_W-1:0]  r_mem_val [DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [7:0]        r_drop;
    logic              r_wrap;
    logic              r_finish;

    logic              w_empty;
    logic              w_full;
    logic              w_last;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_drop;
    logic [TS_W:0]     w_ts_sum;

    assign w_empty  = (r_wr == r_rd);
    assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_last   = (r_state == S_RUN) && (r_cyc == LAST_CYC);
    // First RUN cycle always dumps the current value; later cycles only on change.
    assign w_push   = (r_state == S_RUN) && ((r_cyc == '0) || (value_i != r_last));
    assign w_pop    = !w_empty && out_ready;
    assign w_wr_en  = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_ts_sum = {1'b0, r_ts} + STEP;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (en_i) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (w_empty && !w_push) w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cyc     <= '0;
            r_ts      <= '0;
            r_last    <= '0;
            r_mem_ts  <= '{default: '0};
            r_mem_val <= '{default: '0};
            r_wr      <= '0;
            r_rd      <= '0;
            r_drop    <= '0;
            r_wrap    <= 1'b0;
            r_finish  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_finish <= (r_state == S_DRAIN) && (w_next == S_DONE);
            if (r_state == S_RUN) begin
                r_last <= value_i;
                // Time only advances while another RUN cycle follows.
                if (!w_last) begin
                    r_cyc <= r_cyc + 1'b1;
                    r_ts  <= w_ts_sum[TS_W-1:0];
                    if (w_ts_sum[TS_W]) r_wrap <= 1'b1;
                end
            end
            if (w_wr_en) begin
                r_mem_ts[r_wr[AW-1:0]]  <= r_ts;
                r_mem_val[r_wr[AW-1:0]] <= value_i;
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 1'b1;
        end
    end

    assign out_valid = !w_empty;
    assign out_ts    = r_mem_ts[r_rd[AW-1:0]];
    assign out_value = r_mem_val[r_rd[AW-1:0]];
    assign drop_cnt  = r_drop;
    assign ts_wrap   = r_wrap;
    assign finish_o  = r_finish;
    assign done_o    = (r_state == S_DONE);

endmodule

// File: tb/tb_trace_time_stamper.sv
// Scoreboard bench for trace_time_stamper: a default instance plus a narrow
// timestamp instance driven by the same stimulus for the wrap scenario.
module tb_trace_time_stamper;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic [31:0] value_i = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [47:0] out_ts;
    logic [31:0] out_value;
    logic [7:0]  drop_cnt;
    logic        ts_wrap, finish_o, done_o;

    logic        w_out_valid;
    logic [3:0]  w_out_ts;
    logic [31:0] w_out_value;
    logic [7:0]  w_drop_cnt;
    logic        w_ts_wrap, w_finish_o, w_done_o;

    always #5 clk = ~clk;

    trace_time_stamper #(.PERIOD_UNITS(1), .VAL_W(32), .TS_W(48), .DEPTH(DEPTH), .FINISH_CYC(10)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .value_i(value_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts), .out_value(out_value),
        .drop_cnt(drop_cnt), .ts_wrap(ts_wrap), .finish_o(finish_o), .done_o(done_o));

    trace_time_stamper #(.PERIOD_UNITS(3), .VAL_W(32), .TS_W(4), .DEPTH(DEPTH), .FINISH_CYC(10)) dut_w (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .value_i(value_i),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_ts(w_out_ts), .out_value(w_out_value),
        .drop_cnt(w_drop_cnt), .ts_wrap(w_ts_wrap), .finish_o(w_finish_o), .done_o(w_done_o));

    typedef struct packed {
        logic [47:0] ts;
        logic [31:0] val;
    } rec_t;

    rec_t        q[$];
    logic [3:0]  w_seen[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          m_c;
    int          m_fin;
    int          m_drop;
    logic [31:0] m_last;
    bit          w_col = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle at a negedge: check current head, then model this cycle's pop/push.
    task automatic cyc(input bit cap, input logic [31:0] v, input bit rdy);
        bit psh;
        value_i   = v;
        out_ready = rdy;
        check("valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            check("head_ts", {16'd0, out_ts}, {16'd0, q[0].ts});
            check("head_val", {32'd0, out_value}, {32'd0, q[0].val});
        end
        check("drop", {56'd0, drop_cnt}, 64'(m_drop));
        if (finish_o) m_fin++;
        if (w_col && w_out_valid) w_seen.push_back(w_out_ts);
        if (rdy && q.size() != 0) void'(q.pop_front());
        if (cap) begin
            psh = (m_c == 0) || (v != m_last);
            m_last = v;
            if (psh) begin
                if (q.size() == DEPTH) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    q.push_back('{ts: 48'(m_c), val: v});
                end
            end
            m_c++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en_i  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_ts", {16'd0, out_ts}, 64'd0);
        check("rst_val", {32'd0, out_value}, 64'd0);
        check("rst_drop", {56'd0, drop_cnt}, 64'd0);
        check("rst_wrap", {63'd0, ts_wrap}, 64'd0);
        check("rst_finish", {63'd0, finish_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_w_valid", {63'd0, w_out_valid}, 64'd0);
        q.delete();
        m_drop = 0;
        rst_n  = 1'b1;
        en_i   = 1'b0;
    endtask

    function automatic logic [31:0] val_for(input int mode, input int c);
        case (mode)
            2:       return (c < 3) ? 32'd5 : 32'd7;
            3:       return 32'(c + 100);
            4:       return 32'(c + 200);
            default: return 32'(c & 1);
        endcase
    endfunction

    function automatic bit rdy_for(input int mode, input int c);
        case (mode)
            3:       return 1'b0;
            4:       return (c >= 4);
            default: return 1'b1;
        endcase
    endfunction

    task automatic start_run();
        m_c   = 0;
        m_fin = 0;
        en_i  = 1'b1;
        cyc(0, 32'd0, 1'b1);
        en_i  = 1'b0;
    endtask

    task automatic run_test(input int mode);
        start_run();
        for (int c = 0; c < 10; c++) cyc(1, val_for(mode, c), rdy_for(mode, c));
        if (mode == 3) check("drop6", {56'd0, drop_cnt}, 64'd6);
        if (mode == 4) check("drop0_full_pop", {56'd0, drop_cnt}, 64'd0);
        en_i = 1'b1;
        for (int c = 0; c < 12; c++) cyc(0, 32'(c + 5000), 1'b1);
        en_i = 1'b0;
        check("finish_once", 64'(m_fin), 64'd1);
        check("done", {63'd0, done_o}, 64'd1);
        check("drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        run_test(2);
        do_reset();
        run_test(3);
        do_reset();
        run_test(4);

        do_reset();
        w_seen.delete();
        w_col = 1;
        run_test(5);
        w_col = 0;
        check("wrap_count", 64'(w_seen.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < w_seen.size()) check("wrap_ts", {60'd0, w_seen[i]}, 64'((i * 3) % 16));
        end
        check("wrap_sticky", {63'd0, w_ts_wrap}, 64'd1);
        check("no_wrap_wide", {63'd0, ts_wrap}, 64'd0);

        do_reset();
        start_run();
        for (int c = 0; c < 5; c++) cyc(1, (c < 3) ? 32'd9 : 32'd4, 1'b0);
        check("mid_queued", 64'(q.size()), 64'd2);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_valid", {63'd0, out_valid}, 64'd0);
        check("mid_drop", {56'd0, drop_cnt}, 64'd0);
        check("mid_done", {63'd0, done_o}, 64'd0);
        check("mid_wrap", {63'd0, w_ts_wrap}, 64'd0);
        q.delete();
        m_drop = 0;
        rst_n  = 1'b1;
        run_test(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
